imm_instr_encoder: RTL

- Inverse of the core's immediate generator: packs register/funct fields plus a 32-bit signed immediate into an RV32I instruction word, selected by a 3-bit immediate type.
- Used by the self-test program loader and the trace-replay bench to build instruction memory images in hardware.
- Valid/ready input and output, backed by a 2-entry output buffer.
- Optional immediate range check flags values that do not fit the selected format.

---
 rtl/imm_instr_encoder_if.sv | 36 +++
 rtl/imm_instr_encoder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imm_instr_encoder_if.sv
// imm_instr_encoder_if
//   Request and response channels of the instruction encoder.
//   Request : in_valid/in_ready handshake plus the fields to pack
//             (in_imm_type, in_opcode, in_rd, in_funct3, in_rs1, in_rs2,
//             in_funct7, in_imm).
//   Response: out_valid/out_ready handshake plus out_instr and out_err.
//   slave  : the encoder side.
//   master : the producer/consumer side (loader, bench).
interface imm_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_imm_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport slave (
    input  in_valid, in_imm_type, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, in_imm_type, in_opcode, in_rd, in_funct3,
           in_rs1, in_rs2, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder
//   Packs register/funct fields and a signed 32-bit immediate into an RV32I
//   instruction word according to a 3-bit immediate type (R/I/S/B/U/J),
//   the inverse of the core's immediate generator. Results pass through a
//   2-entry FIFO buffer with valid/ready on both sides.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous, active-low reset
//   bus       : imm_instr_encoder_if.slave (request + response channels)
//   enc_count : number of completed output handshakes, saturating
// Configuration:
//   IMM_ENC_RANGE_CHECK_EN : when defined, out_err also flags immediates that
//   do not fit the selected format (the word is still packed by truncation).
//   Illegal types (110/111) always produce a NOP with out_err=1.
module imm_instr_encoder #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  imm_instr_encoder_if.slave bus,
  output logic [COUNT_W-1:0] enc_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_reg, state_next;
  logic [31:0] head_instr_reg, tail_instr_reg;
  logic        head_err_reg, tail_err_reg;
  logic [COUNT_W-1:0] count_reg;

  logic [31:0] enc_word;
  logic        enc_err;
  logic        push, pop;
  logic        load_head, load_tail, shift_tail;

  // Field packing, purely combinational; registered only when accepted.
  always_comb begin
    enc_word = NOP;
    enc_err  = 1'b0;
    unique case (bus.in_imm_type)
      3'b000: enc_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      3'b001: enc_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3,
                          bus.in_rd, bus.in_opcode};
      3'b010: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                          bus.in_imm[4:0], bus.in_opcode};
      3'b011: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                          bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11],
                          bus.in_opcode};
      3'b100: enc_word = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      3'b101: enc_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                          bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
      default: begin
        enc_word = NOP;
        enc_err  = 1'b1;
      end
    endcase
`ifdef IMM_ENC_RANGE_CHECK_EN
    // An immediate fits when every bit above the format's sign bit matches
    // the sign; branch/jump offsets must additionally be 2-byte aligned.
    unique case (bus.in_imm_type)
      3'b001, 3'b010:
        if (bus.in_imm[31:11] != {21{bus.in_imm[31]}}) enc_err = 1'b1;
      3'b011:
        if ((bus.in_imm[31:12] != {20{bus.in_imm[31]}}) || bus.in_imm[0])
          enc_err = 1'b1;
      3'b100:
        if (bus.in_imm[11:0] != 12'd0) enc_err = 1'b1;
      3'b101:
        if ((bus.in_imm[31:20] != {12{bus.in_imm[31]}}) || bus.in_imm[0])
          enc_err = 1'b1;
      default: ;
    endcase
`endif
  end

  assign bus.in_ready  = (state_reg != FULL);
  assign bus.out_valid = (state_reg != EMPTY);
  assign bus.out_instr = head_instr_reg;
  assign bus.out_err   = head_err_reg;
  assign enc_count     = count_reg;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Next state and buffer steering. A push while ONE and popping goes
  // straight to the head slot since the old head leaves this cycle.
  always_comb begin
    state_next = state_reg;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    unique case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          load_head  = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_next = FULL;
          load_tail  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          shift_tail = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= EMPTY;
      head_instr_reg <= 32'd0;
      head_err_reg   <= 1'b0;
      tail_instr_reg <= 32'd0;
      tail_err_reg   <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (load_head) begin
        head_instr_reg <= enc_word;
        head_err_reg   <= enc_err;
      end else if (shift_tail) begin
        head_instr_reg <= tail_instr_reg;
        head_err_reg   <= tail_err_reg;
      end
      if (load_tail) begin
        tail_instr_reg <= enc_word;
        tail_err_reg   <= enc_err;
      end
      if (pop && (count_reg != {COUNT_W{1'b1}})) begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule
